ap_txn_profiler: RTL and testbench

- Synthesizable profiler that consumes the ap_ctrl_hs handshake and pipelined-loop status signals of a single HLS kernel (the lab5_z1 top).
- Produces one statistics record per completed kernel transaction: latency, loop iterations started and retired, and stall cycles.
- Records drain through a small FIFO on a valid/ready stream toward a trace/readback stage.
- Sits directly downstream of the kernel, tapping its control outputs non-intrusively.

---
 rtl/ap_prof_pkg.sv | 30 +++
 rtl/prof_rec_fifo.sv | 53 +++++
 rtl/ap_txn_profiler.sv | 160 ++++++++++++++++
 tb/tb_ap_txn_profiler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ap_prof_pkg.sv
// Shared types for the ap_ctrl_hs transaction profiler: FSM states, record layout, saturation helper.
// Record carries a start timestamp only when AP_TXN_PROFILER_TIMESTAMP_EN is defined.
package ap_prof_pkg;

   localparam int DROP_W     = 8;
   localparam int SAT_W      = 32;
   localparam int REC_CNT_W  = 32;
   localparam int REC_ITER_W = 16;
   localparam int REC_TS_W   = 48;

   typedef enum logic {IDLE, BUSY} state_t;

   // Field widths are the maximum supported; narrower counters are zero-extended into them.
   typedef struct packed {
`ifdef AP_TXN_PROFILER_TIMESTAMP_EN
      logic [REC_TS_W-1:0]   timestamp;
`endif
      logic [REC_CNT_W-1:0]  latency;
      logic [REC_ITER_W-1:0] iters_in;
      logic [REC_ITER_W-1:0] iters_out;
      logic [REC_CNT_W-1:0]  stalls;
   } prof_rec_t;

   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                input logic [SAT_W-1:0] max,
                                                input logic             en);
      return (en && (v != max)) ? v + SAT_W'(1) : v;
   endfunction

endpackage

// File: rtl/prof_rec_fifo.sv
// First-word-fall-through FIFO of profiler records; head entry is always presented on rdata.
// Pointers carry an extra MSB so full and empty are distinguishable without a counter.
module prof_rec_fifo
   import ap_prof_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      push,
   input  prof_rec_t wdata,
   input  logic      pop,
   output prof_rec_t rdata,
   output logic      full,
   output logic      empty
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

   prof_rec_t   mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         // NOTE: the storage is reset on purpose so the record outputs read zero out of reset; at this depth it is only a few flops.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments keep every register update in this edge based on pre-edge values.
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/ap_txn_profiler.sv
// Profiles ap_ctrl_hs transactions of one HLS kernel and streams one statistics record per transaction.
// Define AP_TXN_PROFILER_TIMESTAMP_EN to add a free-running cycle counter and rec_timestamp.
module ap_txn_profiler
   import ap_prof_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int ITER_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int TS_W       = 48
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ap_start,
   input  logic              ap_ready,
   input  logic              ap_done,
   input  logic              iter_start,
   input  logic              iter_end,
   input  logic              stall,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic [CNT_W-1:0]  rec_latency,
   output logic [ITER_W-1:0] rec_iters_in,
   output logic [ITER_W-1:0] rec_iters_out,
   output logic [CNT_W-1:0]  rec_stalls,
   output logic              busy,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt
`ifdef AP_TXN_PROFILER_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]   rec_timestamp
`endif
);

   if (CNT_W > REC_CNT_W || ITER_W > REC_ITER_W || TS_W > REC_TS_W ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("ap_txn_profiler: unsupported parameter combination");
   end

   localparam logic [SAT_W-1:0] CNT_MAX  = SAT_W'({CNT_W{1'b1}});
   localparam logic [SAT_W-1:0] ITER_MAX = SAT_W'({ITER_W{1'b1}});
   localparam logic [SAT_W-1:0] DROP_MAX = SAT_W'({DROP_W{1'b1}});

   state_t            state;
   logic [CNT_W-1:0]  lat_q, stall_q, base_lat, base_stall, cur_lat, cur_stall;
   logic [ITER_W-1:0] in_q, out_q, base_in, base_out, cur_in, cur_out;
   logic              in_busy, new_txn, done_cyc, pop, drop;
   logic              fifo_full, fifo_empty;
   prof_rec_t         rec_in, head;

   // ap_ready carries nothing the profile needs; the FSM window alone qualifies iterations.
   logic unused_ap_ready;
   assign unused_ap_ready = ap_ready;

   assign in_busy  = (state == BUSY);
   assign done_cyc = (in_busy | ap_start) & ap_done;
   // A start coinciding with done in IDLE is a one-cycle transaction, not a new one.
   assign new_txn  = in_busy ? (ap_done & ap_start) : (ap_start & ~ap_done);
   assign pop      = rec_valid & rec_ready;
   assign drop     = done_cyc & fifo_full & ~pop;

`ifdef AP_TXN_PROFILER_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q, start_ts_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ts_q       <= '0;
         start_ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
         if (new_txn) begin
            start_ts_q <= ts_q;
         end
      end
   end
`endif

   always_comb begin
      // NOTE: every variable gets a default before any branch so no path leaves it unassigned and infers a latch.
      base_lat   = '0;
      base_in    = '0;
      base_out   = '0;
      base_stall = '0;
      if (in_busy) begin
         base_lat   = lat_q;
         base_in    = in_q;
         base_out   = out_q;
         base_stall = stall_q;
      end
      cur_lat   = CNT_W'(sat_inc(SAT_W'(base_lat), CNT_MAX, 1'b1));
      cur_in    = ITER_W'(sat_inc(SAT_W'(base_in), ITER_MAX, iter_start));
      cur_out   = ITER_W'(sat_inc(SAT_W'(base_out), ITER_MAX, iter_end));
      cur_stall = CNT_W'(sat_inc(SAT_W'(base_stall), CNT_MAX, stall));

      rec_in           = '0;
      rec_in.latency   = REC_CNT_W'(cur_lat);
      rec_in.iters_in  = REC_ITER_W'(cur_in);
      rec_in.iters_out = REC_ITER_W'(cur_out);
      rec_in.stalls    = REC_CNT_W'(cur_stall);
`ifdef AP_TXN_PROFILER_TIMESTAMP_EN
      rec_in.timestamp = REC_TS_W'(in_busy ? start_ts_q : ts_q);
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         lat_q    <= '0;
         in_q     <= '0;
         out_q    <= '0;
         stall_q  <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (new_txn) begin
            state   <= BUSY;
            lat_q   <= CNT_W'(1);
            in_q    <= ITER_W'(iter_start);
            out_q   <= ITER_W'(iter_end);
            stall_q <= CNT_W'(stall);
         end else if (done_cyc) begin
            state   <= IDLE;
            lat_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
            stall_q <= '0;
         end else if (in_busy) begin
            lat_q   <= cur_lat;
            in_q    <= cur_in;
            out_q   <= cur_out;
            stall_q <= cur_stall;
         end
         if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= DROP_W'(sat_inc(SAT_W'(drop_cnt), DROP_MAX, 1'b1));
         end
      end
   end

   prof_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (done_cyc),
      .wdata (rec_in),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign busy          = in_busy;
   assign rec_valid     = ~fifo_empty;
   assign rec_latency   = head.latency[CNT_W-1:0];
   assign rec_iters_in  = head.iters_in[ITER_W-1:0];
   assign rec_iters_out = head.iters_out[ITER_W-1:0];
   assign rec_stalls    = head.stalls[CNT_W-1:0];
`ifdef AP_TXN_PROFILER_TIMESTAMP_EN
   assign rec_timestamp = head.timestamp[TS_W-1:0];
`endif

endmodule

// File: tb/tb_ap_txn_profiler.sv
// Scoreboard bench for ap_txn_profiler: directed transactions push hand-computed records, a monitor pops and compares.
// A second instance with CNT_W=4 covers counter saturation.
`timescale 1ns/1ps
module tb_ap_txn_profiler;

   typedef struct packed {
      logic [31:0] lat;
      logic [15:0] i_in;
      logic [15:0] i_out;
      logic [31:0] st;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0;
   logic        iter_start = 1'b0, iter_end = 1'b0, stall = 1'b0;
   logic        rec_ready = 1'b1, sat_ready = 1'b1;
   logic        rec_valid, busy, overflow;
   logic [31:0] rec_latency, rec_stalls;
   logic [15:0] rec_iters_in, rec_iters_out;
   logic [7:0]  drop_cnt;
   logic        sat_valid, sat_busy, sat_overflow;
   logic [3:0]  sat_latency, sat_stalls;
   logic [15:0] sat_iters_in, sat_iters_out;
   logic [7:0]  sat_drop_cnt;
`ifdef AP_TXN_PROFILER_TIMESTAMP_EN
   logic [47:0] rec_timestamp, sat_timestamp, tb_cyc, start_ts;
   always @(posedge clock or posedge reset)
      if (reset) tb_cyc <= '0;
      else       tb_cyc <= tb_cyc + 48'd1;
`endif

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clock = ~clock;

   ap_txn_profiler dut (
      .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
      .iter_start(iter_start), .iter_end(iter_end), .stall(stall),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_latency(rec_latency),
      .rec_iters_in(rec_iters_in), .rec_iters_out(rec_iters_out), .rec_stalls(rec_stalls),
      .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef AP_TXN_PROFILER_TIMESTAMP_EN
      , .rec_timestamp(rec_timestamp)
`endif
   );

   ap_txn_profiler #(.CNT_W(4)) dut_sat (
      .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
      .iter_start(iter_start), .iter_end(iter_end), .stall(stall),
      .rec_valid(sat_valid), .rec_ready(sat_ready), .rec_latency(sat_latency),
      .rec_iters_in(sat_iters_in), .rec_iters_out(sat_iters_out), .rec_stalls(sat_stalls),
      .busy(sat_busy), .overflow(sat_overflow), .drop_cnt(sat_drop_cnt)
`ifdef AP_TXN_PROFILER_TIMESTAMP_EN
      , .rec_timestamp(sat_timestamp)
`endif
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic exp_t mk(input int l, input int i, input int o, input int s);
      exp_t e;
      e.lat   = 32'(l);
      e.i_in  = 16'(i);
      e.i_out = 16'(o);
      e.st    = 32'(s);
      return e;
   endfunction

   // Monitor: a record transfers on the next rising edge whenever valid and ready are seen here.
   always @(negedge clock) begin
      if (!reset && rec_valid && rec_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_record: got lat=%0d in=%0d out=%0d st=%0d with none pending",
                     rec_latency, rec_iters_in, rec_iters_out, rec_stalls);
         end else begin
            mon_e = exp_q.pop_front();
            check("record", {rec_latency, rec_iters_in, rec_iters_out, rec_stalls}, mon_e);
         end
      end
   end

   task automatic drive(input logic s, input logic d, input logic is, input logic ie, input logic st);
      ap_start = s; ap_done = d; iter_start = is; iter_end = ie; stall = st;
      @(posedge clock); #1;
      ap_start = 1'b0; ap_done = 1'b0; iter_start = 1'b0; iter_end = 1'b0; stall = 1'b0;
   endtask

   // One transaction of lat cycles; bit c of each pattern drives that input in cycle c.
   task automatic txn(input int lat, input logic [31:0] isp, input logic [31:0] iep,
                      input logic [31:0] stp, input bit exp_push, input exp_t e, input bit timing);
      for (int c = 0; c < lat; c++) begin
`ifdef AP_TXN_PROFILER_TIMESTAMP_EN
         if (c == 0) start_ts = tb_cyc;
`endif
         if (c == lat - 1 && exp_push) exp_q.push_back(e);
         drive(c == 0, c == lat - 1, isp[c], iep[c], stp[c]);
         if (timing && c == 0 && lat > 1) check("busy_after_start", busy, 1);
         if (timing && c == lat - 2) check("valid_before_done", rec_valid, 0);
      end
      if (timing) begin
         check("valid_after_done", rec_valid, 1);
         check("busy_after_done", busy, 0);
      end
   endtask

   logic [15:0] b2b_s, b2b_d, b2b_i;
   bit          held;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      check("reset_valid", rec_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_overflow", overflow, 0);
      check("reset_drop_cnt", drop_cnt, 0);
      check("reset_latency", rec_latency, 0);
      check("reset_stalls", rec_stalls, 0);
      reset = 1'b0;

      // Stray iteration pulses and a lone ap_done while idle must leave no trace.
      drive(0, 0, 1, 1, 1);
      drive(0, 0, 1, 0, 0);
      drive(0, 1, 0, 0, 0);
      check("idle_done_busy", busy, 0);
      check("idle_done_valid", rec_valid, 0);
      repeat (4) drive(0, 0, 0, 0, 0);

      txn(11, 32'h0000_00FF, 32'h0000_01FE, 32'h0, 1, mk(11, 8, 8, 0), 1);
      repeat (2) drive(0, 0, 0, 0, 0);
      txn(14, 32'h0000_07C7, 32'h0000_0FC6, 32'h0000_0038, 1, mk(14, 8, 8, 3), 1);
      repeat (2) drive(0, 0, 0, 0, 0);
      txn(1, 32'h1, 32'h0, 32'h1, 1, mk(1, 1, 0, 1), 1);
      repeat (2) drive(0, 0, 0, 0, 0);

      // Back-to-back: done+start at cycles 4 and 8; the iteration at cycle 4 counts in both records.
      b2b_s = 16'h0111; b2b_d = 16'h1110; b2b_i = 16'h0010; held = 1'b1;
      for (int c = 0; c < 13; c++) begin
         if (b2b_d[c]) exp_q.push_back(c == 12 ? mk(5, 0, 0, 0) : mk(5, 1, 0, 0));
         drive(b2b_s[c], b2b_d[c], b2b_i[c], 1'b0, 1'b0);
         if (c < 12 && !busy) held = 1'b0;
      end
      check("b2b_busy_held", held, 1);
      repeat (3) drive(0, 0, 0, 0, 0);

      check("pre_overflow_flag", overflow, 0);
      rec_ready = 1'b0;
      for (int k = 2; k <= 7; k++) txn(k, 32'h1, 32'h0, 32'h0, k <= 5, mk(k, 1, 0, 0), 0);
      check("overflow_flag", overflow, 1);
      check("overflow_drop_cnt", drop_cnt, 2);
      check("overflow_valid", rec_valid, 1);
      // Push into the full FIFO in the same cycle as a pop: accepted, nothing dropped.
      exp_q.push_back(mk(3, 0, 0, 0));
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      rec_ready = 1'b1;
      drive(0, 1, 0, 0, 0);
      check("full_push_pop_drop_cnt", drop_cnt, 2);
      for (int i = 0; i < 20 && rec_valid; i++) drive(0, 0, 0, 0, 0);
      check("drain_valid_low", rec_valid, 0);
      check("drain_queue_empty", exp_q.size(), 0);

      // Reset in the middle of a transaction with a record still queued.
      rec_ready = 1'b0;
      txn(3, 32'h0, 32'h0, 32'h0, 0, mk(0, 0, 0, 0), 0);
      check("pre_reset_valid", rec_valid, 1);
      drive(1, 0, 1, 0, 0);
      repeat (4) drive(0, 0, 1, 1, 1);
      check("pre_reset_busy", busy, 1);
      reset = 1'b1;
      #1;
      check("mid_reset_busy", busy, 0);
      check("mid_reset_valid", rec_valid, 0);
      check("mid_reset_latency", rec_latency, 0);
      check("mid_reset_drop_cnt", drop_cnt, 0);
      check("mid_reset_overflow", overflow, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      rec_ready = 1'b1;
      drive(0, 0, 0, 0, 0);
      txn(4, 32'h3, 32'h6, 32'h0, 1, mk(4, 2, 2, 0), 1);
      repeat (2) drive(0, 0, 0, 0, 0);

      // 20-cycle transaction: the CNT_W=4 instance must stick at 15.
      txn(20, 32'h000F_FFFF, 32'h0, 32'h000F_FFFF, 1, mk(20, 20, 0, 20), 1);
      check("sat_valid", sat_valid, 1);
      check("sat_latency", sat_latency, 15);
      check("sat_stalls", sat_stalls, 15);
      check("sat_iters_in", sat_iters_in, 20);
`ifdef AP_TXN_PROFILER_TIMESTAMP_EN
      check("timestamp", rec_timestamp, start_ts);
`endif
      repeat (4) drive(0, 0, 0, 0, 0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
